// File: rtl/serial_add_pkg.sv
// Shared types and default sizing for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_TCNT_W = 5;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequences one full_adder over WIDTH cycles (LSB first) and counts the
// cell's sum/carry output toggles per operation for power estimation.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned TCNT_W = DEF_TCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic [TCNT_W-1:0] toggle_cnt
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned TW1   = TCNT_W + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = {TCNT_W{1'b1}};

  state_e             r_state;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic [TCNT_W-1:0]  r_tcnt;
  logic               r_prev_sum;
  logic               r_prev_carry;
  logic               r_busy;
  logic               r_done;

  logic               w_run;
  logic               w_fa_a;
  logic               w_fa_b;
  logic               w_fa_c;
  logic               w_sum;
  logic               w_carry;
  logic [1:0]         w_tog_inc;
  logic [TW1-1:0]     w_tcnt_sum;
  logic [TCNT_W-1:0]  w_tcnt_nxt;

  // Cell inputs are gated to 0 outside RUN so it shows no activity when idle.
  assign w_run  = (r_state == RUN);
  assign w_fa_a = w_run & r_sh_a[0];
  assign w_fa_b = w_run & r_sh_b[0];
  assign w_fa_c = w_run & r_carry;

  full_adder u_fa (
    .a     (w_fa_a),
    .b     (w_fa_b),
    .c     (w_fa_c),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Saturating toggle count update for the current bit.
  always_comb begin
    w_tog_inc  = {1'b0, w_sum ^ r_prev_sum} + {1'b0, w_carry ^ r_prev_carry};
    w_tcnt_sum = {1'b0, r_tcnt} + TW1'(w_tog_inc);
    if (w_tcnt_sum > {1'b0, TCNT_MAX}) begin
      w_tcnt_nxt = TCNT_MAX;
    end else begin
      w_tcnt_nxt = w_tcnt_sum[TCNT_W-1:0];
    end
  end

  // Controller FSM with shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_carry      <= 1'b0;
      r_bit_cnt    <= '0;
      r_result     <= '0;
      r_cout       <= 1'b0;
      r_tcnt       <= '0;
      r_prev_sum   <= 1'b0;
      r_prev_carry <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sh_a       <= op_a;
            r_sh_b       <= op_b;
            r_carry      <= cin;
            r_bit_cnt    <= '0;
            r_result     <= '0;
            r_cout       <= 1'b0;
            r_tcnt       <= '0;
            r_prev_sum   <= 1'b0;
            r_prev_carry <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sh_a       <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b       <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_result     <= {w_sum, r_result[WIDTH-1:1]};
          r_carry      <= w_carry;
          r_tcnt       <= w_tcnt_nxt;
          r_prev_sum   <= w_sum;
          r_prev_carry <= w_carry;
          r_bit_cnt    <= r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_cout  <= w_carry;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign cout       = r_cout;
  assign toggle_cnt = r_tcnt;

endmodule
